// File: rtl/shift_reg_pkg.sv
// rtl/shift_reg_pkg.sv - mode encodings and shared types for the universal shift register
package shift_reg_pkg;

    localparam int MODE_W = 3;

    typedef logic [MODE_W-1:0] mode_t;

    localparam mode_t MODE_HOLD = 3'b000;
    localparam mode_t MODE_LOAD = 3'b001;
    localparam mode_t MODE_SHL  = 3'b010;
    localparam mode_t MODE_SHR  = 3'b011;
    localparam mode_t MODE_ROL  = 3'b100;
    localparam mode_t MODE_ROR  = 3'b101;
    localparam mode_t MODE_CLR  = 3'b110;

    // Counter width able to hold the value w itself (0..w inclusive)
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/shift_reg_univ_if.sv
// rtl/shift_reg_univ_if.sv - control and data bundle between a user and the universal shift register
interface shift_reg_univ_if
    import shift_reg_pkg::*;
#(
    parameter int WIDTH = 8
);
    localparam int CW = cnt_width(WIDTH);

    logic             en;
    mode_t            mode;
    logic [WIDTH-1:0] d;
    logic             sin;
    logic [WIDTH-1:0] q;
    logic             sout;
    logic [CW-1:0]    cnt;
    logic             full;
    logic             done;

    modport master (
        output en, mode, d, sin,
        input  q, sout, cnt, full, done
    );

    modport slave (
        input  en, mode, d, sin,
        output q, sout, cnt, full, done
    );

endinterface

// File: rtl/shift_reg_univ_sat_counter.sv
// rtl/shift_reg_univ_sat_counter.sv - saturating up-counter with a one-shot hit pulse
module sat_counter #(
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr,
    input  logic          inc,
    input  logic [CW-1:0] max_val,
    output logic [CW-1:0] count,
    output logic          hit
);

    // Count increments stop at max_val; hit fires only on the step that reaches it,
    // so it cannot re-fire while saturated and only re-arms through clr or reset
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
            hit   <= 1'b0;
        end else begin
            hit <= 1'b0;
            if (clr) begin
                count <= '0;
            end else if (inc && (count < max_val)) begin
                count <= count + 1'b1;
                hit   <= ((count + 1'b1) == max_val);
            end
        end
    end

endmodule

// File: rtl/shift_reg_univ.sv
// rtl/shift_reg_univ.sv - universal register: hold, load, clear, shift and rotate with word-completion tracking
module shift_reg_univ
    import shift_reg_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
    input  logic           clk,
    input  logic           reset,
    shift_reg_univ_if.slave bus
);

    localparam int            CW      = cnt_width(WIDTH);
    localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);

    logic [WIDTH-1:0] q_nxt;
    logic             sout_nxt;
    logic             is_shift;
    logic             is_restart;

    // Mode mux: next data/serial-out values plus counter control for the selected operation
    always_comb begin
        q_nxt      = bus.q;
        sout_nxt   = bus.sout;
        is_shift   = 1'b0;
        is_restart = 1'b0;
        case (bus.mode)
            MODE_LOAD: begin
                q_nxt      = bus.d;
                is_restart = 1'b1;
            end
            MODE_CLR: begin
                q_nxt      = '0;
                is_restart = 1'b1;
            end
            MODE_SHL: begin
                q_nxt    = {bus.q[WIDTH-2:0], bus.sin};
                sout_nxt = bus.q[WIDTH-1];
                is_shift = 1'b1;
            end
            MODE_SHR: begin
                q_nxt    = {bus.sin, bus.q[WIDTH-1:1]};
                sout_nxt = bus.q[0];
                is_shift = 1'b1;
            end
            MODE_ROL: begin
                q_nxt    = {bus.q[WIDTH-2:0], bus.q[WIDTH-1]};
                sout_nxt = bus.q[WIDTH-1];
                is_shift = 1'b1;
            end
            MODE_ROR: begin
                q_nxt    = {bus.q[0], bus.q[WIDTH-1:1]};
                sout_nxt = bus.q[0];
                is_shift = 1'b1;
            end
            default: begin
                // HOLD and the reserved encoding leave everything as is
            end
        endcase
    end

    // Data and serial-out registers, updated only under the clock enable
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.q    <= RESET_VAL;
            bus.sout <= 1'b0;
        end else if (bus.en) begin
            bus.q    <= q_nxt;
            bus.sout <= sout_nxt;
        end
    end

    sat_counter #(
        .CW (CW)
    ) u_shift_cnt (
        .clk     (clk),
        .reset   (reset),
        .clr     (bus.en && is_restart),
        .inc     (bus.en && is_shift),
        .max_val (CNT_MAX),
        .count   (bus.cnt),
        .hit     (bus.done)
    );

    assign bus.full = (bus.cnt == CNT_MAX);

endmodule
